// File: rtl/lb_pkg.sv
// Shared types and helpers for the line-buffer controller and its raster counter.
package lb_pkg;

  localparam int NUM_LINES_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 14;
  localparam int LINE_IDX_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } lb_state_t;

  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/line_buffer_raster_counter.sv
// Column/row raster position with end-of-line and end-of-frame flags.
module raster_counter #(
  parameter int COL_W = 14,
  parameter int ROW_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             adv,
  input  logic [COL_W:0]   width,
  input  logic [ROW_W-1:0] height,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_last,
  output logic             frame_last
);

  localparam logic [COL_W:0]   ONE_W = (COL_W + 1)'(1);
  localparam logic [ROW_W-1:0] ONE_H = ROW_W'(1);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic             row_last;

  // width is one bit wider than col so a full 2^COL_W line still compares
  assign col_last   = ({1'b0, col_reg} == width - ONE_W);
  assign row_last   = (row_reg == height - ONE_H);
  assign frame_last = col_last & row_last;
  assign col        = col_reg;
  assign row        = row_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (adv) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_reg + ONE_H;
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequences a NUM_LINES-row BRAM line buffer: primes NUM_LINES-1 rows, then
// emits one window-column strobe per accepted pixel with backpressure.
module line_buffer_ctrl
  import lb_pkg::*;
#(
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_IDX_W = LINE_IDX_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   cfg_width,
  input  logic [15:0]           cfg_height,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  lb_we,
  output logic [ADDR_WIDTH-1:0] lb_wr_addr,
  output logic [DATA_WIDTH-1:0] lb_din,
  output logic                  lb_eol,
  output logic                  lb_rd_adv,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_pixel,
  output logic [ADDR_WIDTH-1:0] m_col,
  output logic [LINE_IDX_W-1:0] m_top_line,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] MAX_WIDTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [15:0]         MIN_HEIGHT     = 16'(NUM_LINES);
  localparam logic [15:0]         LAST_PRIME_ROW = 16'(NUM_LINES - 2);

  lb_state_t             state_reg;
  logic [ADDR_WIDTH:0]   width_reg;
  logic [15:0]           height_reg;
  logic [LINE_IDX_W-1:0] wr_line_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  cfg_err_reg;
  logic                  m_valid_reg;
  logic [DATA_WIDTH-1:0] m_pixel_reg;
  logic [ADDR_WIDTH-1:0] m_col_reg;
  logic [LINE_IDX_W-1:0] m_top_line_reg;
  logic                  m_last_reg;

  logic [ADDR_WIDTH-1:0] col;
  logic [15:0]           row;
  logic                  col_last;
  logic                  frame_last;
  logic                  cfg_ok;
  logic                  start_ok;
  logic                  accept;
  logic [LINE_IDX_W-1:0] wr_line_inc;

  assign cfg_ok   = (cfg_width != '0) && (cfg_width <= MAX_WIDTH) && (cfg_height >= MIN_HEIGHT);
  assign start_ok = (state_reg == ST_IDLE) && start && cfg_ok;

  // Intake is gated by reset so an aborted frame issues no further writes or eols.
  assign s_ready = !reset && ((state_reg == ST_PRIME) || ((state_reg == ST_STREAM) && m_ready));
  assign accept  = s_valid && s_ready;

  assign lb_we      = accept;
  assign lb_wr_addr = col;
  assign lb_din     = s_data;
  assign lb_eol     = accept && col_last;
  assign lb_rd_adv  = accept && (state_reg == ST_STREAM) && !col_last;

  assign wr_line_inc = LINE_IDX_W'(inc_mod(32'(wr_line_reg), NUM_LINES));

  raster_counter #(
    .COL_W (ADDR_WIDTH),
    .ROW_W (16)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .adv        (accept),
    .width      (width_reg),
    .height     (height_reg),
    .col        (col),
    .row        (row),
    .col_last   (col_last),
    .frame_last (frame_last)
  );

  // Tracks the buffer's own unreset slot pointer, so it must survive reset too.
  always_ff @(posedge clk) begin
    if (lb_eol) begin
      wr_line_reg <= wr_line_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      width_reg      <= '0;
      height_reg     <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_pixel_reg    <= '0;
      m_col_reg      <= '0;
      m_top_line_reg <= '0;
      m_last_reg     <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              width_reg  <= cfg_width;
              height_reg <= cfg_height;
              busy_reg   <= 1'b1;
              state_reg  <= ST_PRIME;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        ST_PRIME: begin
          if (lb_eol && (row == LAST_PRIME_ROW)) begin
            state_reg <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            m_valid_reg    <= 1'b1;
            m_pixel_reg    <= s_data;
            m_col_reg      <= col;
            m_top_line_reg <= wr_line_inc;
            m_last_reg     <= frame_last;
            if (frame_last) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign cfg_err    = cfg_err_reg;
  assign m_valid    = m_valid_reg;
  assign m_pixel    = m_pixel_reg;
  assign m_col      = m_col_reg;
  assign m_top_line = m_top_line_reg;
  assign m_last     = m_last_reg;

endmodule
